// File: rtl/awgn_channel.sv
// AWGN channel stage: scales external Gaussian noise by a frame-committed
// sigma and adds it to an I/Q symbol stream with saturation (3-cycle latency).
module awgn_channel #(
    parameter int          NBT_SIG   = 8,
    parameter int          NBF_SIG   = 7,
    parameter int          NBT_GNG   = 16,
    parameter int          NBF_GNG   = 11,
    parameter int          NBT_SIGMA = 8,
    parameter int          NBF_SIGMA = 7,
    parameter logic [NBT_SIGMA-1:0] SIGMA_RST = 8'h1c,
    parameter int          NB_CNT    = 16
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    input  logic                 i_sof,
    input  logic [NBT_SIG-1:0]   i_sig_I,
    input  logic [NBT_SIG-1:0]   i_sig_Q,
    input  logic                 i_gng_valid,
    input  logic [NBT_GNG-1:0]   i_gng_I,
    input  logic [NBT_GNG-1:0]   i_gng_Q,
    input  logic [NBT_SIGMA-1:0] i_sigma,
    input  logic                 i_sigma_load,
    input  logic                 i_bypass,
    input  logic                 i_clr_cnt,
    output logic                 o_valid,
    output logic                 o_sof,
    output logic [NBT_SIG-1:0]   o_sig_I,
    output logic [NBT_SIG-1:0]   o_sig_Q,
    output logic [NBT_SIGMA-1:0] o_sigma_active,
    output logic [NB_CNT-1:0]    o_sat_cnt
);

    localparam int SH  = NBF_GNG + NBF_SIGMA - NBF_SIG;
    localparam int NBP = NBT_GNG + NBT_SIGMA;
    localparam int NBW = NBP - SH;
    localparam int NBS = ((NBW > NBT_SIG) ? NBW : NBT_SIG) + 1;

    localparam logic [NBT_SIG-1:0] MAXV = {1'b0, {(NBT_SIG-1){1'b1}}};
    localparam logic [NBT_SIG-1:0] MINV = {1'b1, {(NBT_SIG-1){1'b0}}};

    // sigma control
    logic [NBT_SIGMA-1:0] shadow_q, shadow_d;
    logic [NBT_SIGMA-1:0] active_q, active_d;
    logic                 commit;

    // stage 1
    logic                 s1_v_q, s1_sof_q;
    logic [NBT_SIG-1:0]   s1_sigI_q, s1_sigQ_q;
    logic [NBT_GNG-1:0]   s1_nI_q, s1_nQ_q;
    logic [NBT_SIGMA-1:0] s1_sigma_q;
    logic [NBT_GNG-1:0]   s1_nI_d, s1_nQ_d;

    // stage 2
    logic                 s2_v_q, s2_sof_q;
    logic [NBT_SIG-1:0]   s2_sigI_q, s2_sigQ_q;
    logic [NBW-1:0]       s2_nI_q, s2_nQ_q;
    logic [NBP-1:0]       prodI, prodQ;

    // stage 3
    logic                 s3_v_q, s3_sof_q;
    logic [NBT_SIG-1:0]   s3_I_q, s3_Q_q;
    logic [NBT_SIG-1:0]   s3_I_d, s3_Q_d;
    logic [NBS-1:0]       sumI, sumQ;
    logic                 satI, satQ, cnt_inc;
    logic [NB_CNT-1:0]    cnt_q, cnt_d;

    logic                 unused_lsb;

    assign commit = i_valid & i_sof;

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        if (commit) begin
            active_d = shadow_q;
        end
        if (i_sigma_load) begin
            shadow_d = i_sigma;
        end
    end

    always_comb begin
        s1_nI_d = '0;
        s1_nQ_d = '0;
        if (i_gng_valid && !i_bypass) begin
            s1_nI_d = i_gng_I;
            s1_nQ_d = i_gng_Q;
        end
    end

    // both operands sign-extended to product width, low NBP bits exact
    assign prodI = {{NBT_SIGMA{s1_nI_q[NBT_GNG-1]}}, s1_nI_q}
                 * {{NBT_GNG{s1_sigma_q[NBT_SIGMA-1]}}, s1_sigma_q};
    assign prodQ = {{NBT_SIGMA{s1_nQ_q[NBT_GNG-1]}}, s1_nQ_q}
                 * {{NBT_GNG{s1_sigma_q[NBT_SIGMA-1]}}, s1_sigma_q};

    // dropping the low SH bits of a two's complement value is a floor
    assign unused_lsb = ^{prodI[SH-1:0], prodQ[SH-1:0]};

    assign sumI = {{(NBS-NBT_SIG){s2_sigI_q[NBT_SIG-1]}}, s2_sigI_q}
                + {{(NBS-NBW){s2_nI_q[NBW-1]}}, s2_nI_q};
    assign sumQ = {{(NBS-NBT_SIG){s2_sigQ_q[NBT_SIG-1]}}, s2_sigQ_q}
                + {{(NBS-NBW){s2_nQ_q[NBW-1]}}, s2_nQ_q};

    function automatic logic [NBT_SIG:0] saturate(input logic [NBS-1:0] s);
        logic [NBS-NBT_SIG:0] top;
        top = s[NBS-1:NBT_SIG-1];
        if ((&top) || !(|top)) begin
            return {1'b0, s[NBT_SIG-1:0]};
        end
        return {1'b1, (s[NBS-1] ? MINV : MAXV)};
    endfunction

    always_comb begin
        {satI, s3_I_d} = saturate(sumI);
        {satQ, s3_Q_d} = saturate(sumQ);
    end

    assign cnt_inc = s2_v_q & (satI | satQ);

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr_cnt) begin
            cnt_d = '0;
        end else if (cnt_inc && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            shadow_q <= SIGMA_RST;
            active_q <= SIGMA_RST;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            s1_v_q     <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_sigI_q  <= '0;
            s1_sigQ_q  <= '0;
            s1_nI_q    <= '0;
            s1_nQ_q    <= '0;
            s1_sigma_q <= '0;
        end else begin
            s1_v_q     <= i_valid;
            s1_sof_q   <= commit;
            s1_sigI_q  <= i_sig_I;
            s1_sigQ_q  <= i_sig_Q;
            s1_nI_q    <= s1_nI_d;
            s1_nQ_q    <= s1_nQ_d;
            s1_sigma_q <= active_d;
        end
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            s2_v_q    <= 1'b0;
            s2_sof_q  <= 1'b0;
            s2_sigI_q <= '0;
            s2_sigQ_q <= '0;
            s2_nI_q   <= '0;
            s2_nQ_q   <= '0;
        end else begin
            s2_v_q    <= s1_v_q;
            s2_sof_q  <= s1_sof_q;
            s2_sigI_q <= s1_sigI_q;
            s2_sigQ_q <= s1_sigQ_q;
            s2_nI_q   <= prodI[NBP-1:SH];
            s2_nQ_q   <= prodQ[NBP-1:SH];
        end
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            s3_v_q   <= 1'b0;
            s3_sof_q <= 1'b0;
            s3_I_q   <= '0;
            s3_Q_q   <= '0;
            cnt_q    <= '0;
        end else begin
            s3_v_q   <= s2_v_q;
            s3_sof_q <= s2_sof_q;
            s3_I_q   <= s3_I_d;
            s3_Q_q   <= s3_Q_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_valid        = s3_v_q;
    assign o_sof          = s3_sof_q;
    assign o_sig_I        = s3_I_q;
    assign o_sig_Q        = s3_Q_q;
    assign o_sigma_active = active_q;
    assign o_sat_cnt      = cnt_q;

endmodule

// File: tb/tb_awgn_channel.sv
// Randomised bench for awgn_channel against an integer-arithmetic model.
module tb_awgn_channel;

    localparam int NBC  = 4;
    localparam int CMAX = (1 << NBC) - 1;

    logic            clk = 1'b0;
    logic            i_reset;
    logic            i_valid, i_sof;
    logic [7:0]      i_sig_I, i_sig_Q;
    logic            i_gng_valid;
    logic [15:0]     i_gng_I, i_gng_Q;
    logic [7:0]      i_sigma;
    logic            i_sigma_load, i_bypass, i_clr_cnt;
    logic            o_valid, o_sof;
    logic [7:0]      o_sig_I, o_sig_Q;
    logic [7:0]      o_sigma_active;
    logic [NBC-1:0]  o_sat_cnt;

    awgn_channel #(.NB_CNT(NBC)) dut (
        .clk(clk), .i_reset(i_reset),
        .i_valid(i_valid), .i_sof(i_sof),
        .i_sig_I(i_sig_I), .i_sig_Q(i_sig_Q),
        .i_gng_valid(i_gng_valid),
        .i_gng_I(i_gng_I), .i_gng_Q(i_gng_Q),
        .i_sigma(i_sigma), .i_sigma_load(i_sigma_load),
        .i_bypass(i_bypass), .i_clr_cnt(i_clr_cnt),
        .o_valid(o_valid), .o_sof(o_sof),
        .o_sig_I(o_sig_I), .o_sig_Q(o_sig_Q),
        .o_sigma_active(o_sigma_active),
        .o_sat_cnt(o_sat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        bit s;
        int i;
        int q;
        bit sat;
    } ent_t;

    ent_t pq[$];
    int   sh_m, act_m, cnt_m;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input int x, input int bits);
        int half = 1 << (bits - 1);
        return (x >= half) ? x - 2 * half : x;
    endfunction

    // noise in units of 2^-7: floor(g * s / 2^11)
    function automatic int scale(input int g, input int s);
        int p = g * s;
        return (p >= 0) ? p / 2048 : -((-p + 2047) / 2048);
    endfunction

    function automatic int clampv(input int x);
        if (x > 127) return 127;
        if (x < -128) return -128;
        return x;
    endfunction

    task automatic model_reset();
        ent_t z;
        z = '{v: 0, s: 0, i: 0, q: 0, sat: 0};
        pq.delete();
        pq.push_back(z);
        pq.push_back(z);
        sh_m  = 'h1c;
        act_m = 'h1c;
        cnt_m = 0;
    endtask

    task automatic cyc(input bit v, input bit sof, input int sI,
                       input int sQ, input bit gv, input int gI,
                       input int gQ, input int sg, input bit ld,
                       input bit byp, input bit clr);
        ent_t e;
        int   use_s, nI, nQ, tI, tQ;
        i_valid      = v;
        i_sof        = sof;
        i_sig_I      = sI[7:0];
        i_sig_Q      = sQ[7:0];
        i_gng_valid  = gv;
        i_gng_I      = gI[15:0];
        i_gng_Q      = gQ[15:0];
        i_sigma      = sg[7:0];
        i_sigma_load = ld;
        i_bypass     = byp;
        i_clr_cnt    = clr;
        if (v && sof) act_m = sh_m;
        use_s = act_m;
        if (ld) sh_m = sg & 'hff;
        nI = (gv && !byp) ? scale(sx(gI & 'hffff, 16), use_s) : 0;
        nQ = (gv && !byp) ? scale(sx(gQ & 'hffff, 16), use_s) : 0;
        tI = sx(sI & 'hff, 8) + nI;
        tQ = sx(sQ & 'hff, 8) + nQ;
        e.v   = v;
        e.s   = v & sof;
        e.i   = clampv(tI);
        e.q   = clampv(tQ);
        e.sat = (tI != e.i) || (tQ != e.q);
        pq.push_back(e);
        if (pq.size() > 3) void'(pq.pop_front());
        if (clr) cnt_m = 0;
        else if (pq[0].v && pq[0].sat && cnt_m < CMAX) cnt_m++;
        @(posedge clk);
        #1;
        chk("valid", {31'd0, o_valid}, {31'd0, pq[0].v});
        chk("sof", {31'd0, o_sof}, {31'd0, pq[0].s});
        if (pq[0].v) begin
            chk("sig_I", {24'd0, o_sig_I}, pq[0].i & 'hff);
            chk("sig_Q", {24'd0, o_sig_Q}, pq[0].q & 'hff);
        end
        chk("sigma_act", {24'd0, o_sigma_active}, act_m);
        chk("sat_cnt", {{(32-NBC){1'b0}}, o_sat_cnt}, cnt_m);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        i_valid = 0; i_sof = 0; i_sig_I = 0; i_sig_Q = 0;
        i_gng_valid = 0; i_gng_I = 0; i_gng_Q = 0; i_sigma = 0;
        i_sigma_load = 0; i_bypass = 0; i_clr_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        i_reset = 1'b1;
        model_reset();
    endtask

    initial begin
        do_reset();
        chk("rst_sigma", {24'd0, o_sigma_active}, 32'h1c);
        chk("rst_cnt", {{(32-NBC){1'b0}}, o_sat_cnt}, 0);
        chk("rst_valid", {31'd0, o_valid}, 0);
        idle(3);

        // sigma load then commit on sof; later load waits for next sof
        cyc(0, 0, 0, 0, 0, 0, 0, 'h10, 1, 0, 0);
        cyc(1, 1, 'h20, 0, 1, 'h0800, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 'h40, 1, 0, 0);
        cyc(1, 0, 'h20, 0, 1, 'h0800, 0, 0, 0, 0, 0);
        chk("tp2_I", {24'd0, o_sig_I}, 32'h30);
        chk("tp2_sof", {31'd0, o_sof}, 1);
        idle(1);
        cyc(1, 1, 'h00, 0, 1, 'h0800, 0, 0, 0, 0, 0);
        idle(3);

        // floor truncation
        cyc(0, 0, 0, 0, 0, 0, 0, 'h7f, 1, 0, 0);
        cyc(1, 1, 0, 0, 1, 'h0001, 'h0001, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 'hffff, 'hffff, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("trunc_pos", {24'd0, o_sig_I}, 32'h00);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("trunc_neg", {24'd0, o_sig_I}, 32'hff);
        idle(2);

        // saturation and counter
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 'h1c, 1, 0, 0);
        cyc(1, 1, 'h7f, 0, 1, 'h0800, 0, 0, 0, 0, 0);
        idle(2);
        chk("sat_hi", {24'd0, o_sig_I}, 32'h7f);
        chk("sat_cnt1", {{(32-NBC){1'b0}}, o_sat_cnt}, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 'h10, 1, 0, 0);
        cyc(1, 1, 0, 'h80, 1, 0, 'hf800, 0, 0, 0, 0);
        cyc(1, 0, 'h7f, 'h80, 1, 'h0800, 'hf800, 0, 0, 0, 0);
        idle(2);
        chk("sat_lo", {24'd0, o_sig_Q}, 32'h80);
        chk("sat_cnt3", {{(32-NBC){1'b0}}, o_sat_cnt}, 3);

        // bypass and gng_valid=0 bursts with bubbles
        for (int k = 0; k < 60; k++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                $urandom, $urandom, 1, $urandom, $urandom, 0, 0, 1, 0);
        for (int k = 0; k < 60; k++)
            cyc($urandom_range(0, 2) != 0, 0, $urandom, $urandom, 0,
                $urandom, $urandom, 0, 0, 0, 0);
        idle(3);

        // counter saturates at all-ones
        for (int k = 0; k < CMAX + 5; k++)
            cyc(1, 0, 'h7f, 'h80, 1, 'h0800, 'hf800, 0, 0, 0, 0);
        idle(3);
        chk("cnt_hold", {{(32-NBC){1'b0}}, o_sat_cnt}, CMAX);

        // clear coincident with a saturated output
        cyc(1, 0, 'h7f, 0, 1, 'h0800, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("clr_wins", {{(32-NBC){1'b0}}, o_sat_cnt}, 0);

        // load and sof together commit the old shadow
        cyc(0, 0, 0, 0, 0, 0, 0, 'h22, 1, 0, 0);
        cyc(1, 1, 0, 0, 1, 'h0800, 0, 'h44, 1, 0, 0);
        chk("ld_sof_old", {24'd0, o_sigma_active}, 32'h22);
        cyc(1, 1, 0, 0, 1, 'h0800, 0, 0, 0, 0, 0);
        chk("ld_sof_next", {24'd0, o_sigma_active}, 32'h44);
        idle(3);

        // random mix
        for (int k = 0; k < 400; k++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                $urandom, $urandom, $urandom_range(0, 7) != 0,
                $urandom, $urandom, $urandom_range(0, 127),
                $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 31) == 0);

        // asynchronous reset in mid-stream
        for (int k = 0; k < 4; k++)
            cyc(1, k == 0, 'h7f, 'h80, 1, 'h0800, 'hf800, 0, 0, 0, 0);
        #2;
        i_reset = 1'b0;
        #1;
        chk("arst_valid", {31'd0, o_valid}, 0);
        chk("arst_sof", {31'd0, o_sof}, 0);
        chk("arst_I", {24'd0, o_sig_I}, 0);
        chk("arst_Q", {24'd0, o_sig_Q}, 0);
        chk("arst_cnt", {{(32-NBC){1'b0}}, o_sat_cnt}, 0);
        chk("arst_sigma", {24'd0, o_sigma_active}, 32'h1c);
        do_reset();
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/awgn_channel.md
Name: awgn_channel

Overview:
Parametrised AWGN channel stage for the I/Q link simulator. It takes a symbol stream and independent S(16,11) Gaussian samples from two external gng cores, scales the noise by a runtime-programmable sigma, and adds the noise to the signal with saturation. Sigma changes are double-buffered and commit only on a frame boundary. The output is a fixed 3-cycle pipeline. The block also counts saturated output samples.

Parameters:
NBT_SIG, 8, total bits of signal in/out
NBF_SIG, 7, fractional bits of signal in/out
NBT_GNG, 16, total bits of GNG samples
NBF_GNG, 11, fractional bits of GNG samples
NBT_SIGMA, 8, total bits of sigma (unsigned magnitude in signed container)
NBF_SIGMA, 7, fractional bits of sigma
SIGMA_RST, 8'h1c, active/shadow sigma after reset (7 dB)
NB_CNT, 16, saturation counter width

Ports:
clk  in  1  system clock
i_reset  in  1  reset, asynchronous, active-low
i_valid  in  1  input sample valid
i_sof  in  1  start of frame, qualified by i_valid
i_sig_I  in  NBT_SIG  signal I, S(NBT_SIG,NBF_SIG)
i_sig_Q  in  NBT_SIG  signal Q
i_gng_valid  in  1  GNG samples valid (both cores)
i_gng_I  in  NBT_GNG  noise I, S(NBT_GNG,NBF_GNG)
i_gng_Q  in  NBT_GNG  noise Q
i_sigma  in  NBT_SIGMA  new sigma
i_sigma_load  in  1  write i_sigma into shadow register
i_bypass  in  1  1: noise forced to zero
i_clr_cnt  in  1  synchronous clear of o_sat_cnt
o_valid  out  1  output valid
o_sof  out  1  delayed i_sof
o_sig_I  out  NBT_SIG  signal+noise I
o_sig_Q  out  NBT_SIG  signal+noise Q
o_sigma_active  out  NBT_SIGMA  sigma currently applied
o_sat_cnt  out  NB_CNT  count of saturated I or Q samples

Behaviour:
- Reset (async assert, sync deassert internally not required): all pipeline regs, o_valid, o_sof, o_sig_I/Q = 0, o_sat_cnt = 0, shadow and active sigma = SIGMA_RST.
- Shadow sigma: loads i_sigma on any cycle with i_sigma_load=1.
- Active sigma commit: on a cycle with i_valid & i_sof, active <= shadow. That sample and all later samples use the new value. If i_sigma_load and i_valid&i_sof occur together, the commit uses the old shadow and the new value waits for the next frame. With no traffic (i_valid=0 for the whole cycle), nothing commits.
- No backpressure. Every i_valid sample produces an output exactly 3 cycles later: o_valid, o_sof and data are aligned. i_valid=0 bubbles propagate.
- Stage 1 registers sig, sof, valid, the noise and the committed sigma. Noise is taken as 0 when i_gng_valid=0 or i_bypass=1.
- Stage 2: prod = noise*sigma, S(NBT_GNG+NBT_SIGMA, NBF_GNG+NBF_SIGMA), default S(24,18). Then an arithmetic right shift by (NBF_GNG+NBF_SIGMA-NBF_SIG) with floor truncation, no rounding.
- Stage 3: sum = sig + shifted noise at full width. Saturate to NBT_SIG: overflow gives max positive 0x7F, underflow gives max negative 0x80.
- Saturation counter: increments by 1 per output sample in which I or Q (or both) saturated, counting only when o_valid. It holds at all-ones and never wraps. If i_clr_cnt and an increment coincide, the clear wins and the result is 0.
- o_sigma_active reflects the active register immediately, not delayed by the pipeline.

Test Plan:
1. Release reset with no load -> o_sigma_active=0x1c, o_sat_cnt=0, o_valid=0. Assert reset mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
2. Load sigma 0x10, send sof with sig_I=0x20, gng_I=0x0800 -> 3 cycles later o_valid=1, o_sof=1, o_sig_I=0x30. The next frame's sample uses the updated sigma only after its sof.
3. Truncation: sigma 0x7F, sig 0x00, gng 0x0001 -> out 0x00. gng 0xFFFF -> out 0xFF (floor).
4. Saturation: sigma 0x1c, sig_I=0x7F, gng_I=0x0800 -> 0x7F and o_sat_cnt=1. sig_Q=0x80, gng_Q=0xF800, sigma 0x10 -> 0x80, count +1. Both I and Q saturating in one sample -> count +1.
5. Bypass, or gng_valid=0, with random gng values -> o_sig equals i_sig delayed 3 cycles. A burst with bubbles preserves the valid pattern exactly.
6. Force the counter to all-ones -> it holds. A coincident clr and saturation -> 0. Simultaneous i_sigma_load and sof -> the old shadow is committed.
